// File: rtl/mdr_pkg.sv
// Shared types and default sizing for the MAR/MDR memory stage.
// The access-abort logic in mdr_unit is only built when MEM_TIMEOUT_EN is defined.
package mdr_pkg;

    localparam int DEF_DATA_W  = 32;
    localparam int DEF_TIMEOUT = 15;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RD   = 2'd1,
        S_WR   = 2'd2,
        S_DONE = 2'd3
    } mdr_state_t;

endpackage

// File: rtl/mdr_unit_load_reg.sv
// Generic width register with synchronous active-high reset and load enable.
// Used for both MAR and MDR; any data selection happens outside this block.
module load_reg #(
    parameter int W = 32
) (
    input  logic         clk_i,
    input  logic         reset_i,
    input  logic         ld_i,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    logic [W-1:0] data_q;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            data_q <= '0;
        end else if (ld_i) begin
            data_q <= d_i;
        end
    end

    assign q_o = data_q;

endmodule

// File: rtl/mdr_unit.sv
// MAR/MDR stage with a request/ready handshake to external memory.
// Define MEM_TIMEOUT_EN to build the wait counter that aborts stalled accesses and drives err.
module mdr_unit
    import mdr_pkg::*;
#(
    parameter int DATA_W  = DEF_DATA_W,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic [DATA_W-1:0] bus_in,
    input  logic              ld_mar,
    input  logic              ld_mdr,
    input  logic              rd_req,
    input  logic              wr_req,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic [DATA_W-1:0] mar,
    output logic [DATA_W-1:0] mdr,
    output logic [DATA_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_rd,
    output logic              mem_wr,
    output logic              busy,
    output logic              done,
    output logic              err
);

    mdr_state_t        state_q;
    logic              mem_rd_q;
    logic              mem_wr_q;
    logic              done_q;
    logic              isIdle;
    logic              timeoutHit;
    logic              marLoad;
    logic              mdrLoad;
    logic [DATA_W-1:0] mdr_d;

    assign isIdle = (state_q == S_IDLE);

    // Bus loads are honoured only while idle so MAR/MDR hold still during an access;
    // a completing read takes priority as the only busy-time MDR writer.
    assign marLoad = isIdle && ld_mar;
    assign mdrLoad = (isIdle && ld_mdr) || ((state_q == S_RD) && mem_ready);
    assign mdr_d   = (state_q == S_RD) ? mem_rdata : bus_in;

    load_reg #(.W(DATA_W)) u_marReg (
        .clk_i   (Clk),
        .reset_i (Reset),
        .ld_i    (marLoad),
        .d_i     (bus_in),
        .q_o     (mar)
    );

    load_reg #(.W(DATA_W)) u_mdrReg (
        .clk_i   (Clk),
        .reset_i (Reset),
        .ld_i    (mdrLoad),
        .d_i     (mdr_d),
        .q_o     (mdr)
    );

`ifdef MEM_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] waitCnt_q;
    logic             err_q;

    assign timeoutHit = (waitCnt_q == CNT_W'(TIMEOUT - 1)) && !mem_ready;
    assign err        = err_q;
`else
    assign timeoutHit = 1'b0;
    assign err        = 1'b0;
`endif

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q   <= S_IDLE;
            mem_rd_q  <= 1'b0;
            mem_wr_q  <= 1'b0;
            done_q    <= 1'b0;
`ifdef MEM_TIMEOUT_EN
            waitCnt_q <= '0;
            err_q     <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    // Read beats write when both are requested; the write is simply dropped.
                    if (rd_req) begin
                        state_q  <= S_RD;
                        mem_rd_q <= 1'b1;
                    end else if (wr_req) begin
                        state_q  <= S_WR;
                        mem_wr_q <= 1'b1;
                    end
`ifdef MEM_TIMEOUT_EN
                    if (rd_req || wr_req) begin
                        waitCnt_q <= '0;
                        err_q     <= 1'b0;
                    end
`endif
                end
                S_RD, S_WR: begin
                    if (mem_ready || timeoutHit) begin
                        state_q  <= S_DONE;
                        mem_rd_q <= 1'b0;
                        mem_wr_q <= 1'b0;
                        done_q   <= 1'b1;
                    end
`ifdef MEM_TIMEOUT_EN
                    if (!mem_ready) begin
                        waitCnt_q <= waitCnt_q + 1'b1;
                    end
                    if (timeoutHit) begin
                        err_q <= 1'b1;
                    end
`endif
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign mem_addr  = mar;
    assign mem_wdata = mdr;
    assign mem_rd    = mem_rd_q;
    assign mem_wr    = mem_wr_q;
    assign done      = done_q;
    assign busy      = !isIdle;

endmodule
